// File: rtl/axil_reg_responder_if.sv
// AXI4-Lite slave-side bus bundle for axil_reg_responder.
// The signal names keep the original S_AXI_* port names so existing code can still refer to them.
interface axil_reg_responder_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axil_reg_responder.sv
// AXI4-Lite slave with four 32-bit registers at offsets 0x0-0xC.
// Write address and write data are taken independently, each into a one-deep slot; reads complete in one cycle.
module axil_reg_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  axil_reg_responder_if.slave             s_axi,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [3:0]                      reg_wr_pulse
);
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned NB = DW / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  logic              ready_q;
  logic              aw_full_q, aw_full_d;
  logic [AW-1:0]     aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  logic [DW-1:0]     w_data_q, w_data_d;
  logic [NB-1:0]     w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  resp_e             bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  resp_e             rresp_q, rresp_d;
  logic [3:0][DW-1:0] regs_q, regs_d;
  logic [3:0]        pulse_q, pulse_d;

  logic              awready, wready, arready;
  logic              aw_hs, w_hs, ar_hs;
  logic              do_write, wr_oor, rd_oor;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NB-1:0]     wr_strb;
  logic              unused_ok;

  // ready_q keeps all READYs low for the first cycle after reset is released
  assign awready = ready_q && !aw_full_q;
  assign wready  = ready_q && !w_full_q;
  assign arready = ready_q && !rvalid_q;

  assign aw_hs = s_axi.S_AXI_AWVALID && awready;
  assign w_hs  = s_axi.S_AXI_WVALID && wready;
  assign ar_hs = s_axi.S_AXI_ARVALID && arready;

  // A channel handshaking this cycle is forwarded straight into the write, so the register
  // update and BVALID land on the edge that completes the later of the two handshakes.
  assign wr_addr  = aw_full_q ? aw_addr_q : s_axi.S_AXI_AWADDR;
  assign wr_data  = w_full_q ? w_data_q : s_axi.S_AXI_WDATA;
  assign wr_strb  = w_full_q ? w_strb_q : s_axi.S_AXI_WSTRB;
  assign do_write = (aw_full_q || aw_hs) && (w_full_q || w_hs) &&
                    (!bvalid_q || s_axi.S_AXI_BREADY);

  assign wr_oor = (wr_addr >> 4) != '0;
  assign rd_oor = (s_axi.S_AXI_ARADDR >> 4) != '0;

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    pulse_d   = '0;
    if (do_write) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_oor ? RESP_SLVERR : RESP_OKAY;
      if (!wr_oor) begin
        pulse_d[wr_addr[3:2]] = 1'b1;
        for (int unsigned i = 0; i < NB; i++) begin
          if (wr_strb[i]) begin
            regs_d[wr_addr[3:2]][8*i +: 8] = wr_data[8*i +: 8];
          end
        end
      end
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        aw_addr_d = s_axi.S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        w_data_d = s_axi.S_AXI_WDATA;
        w_strb_d = s_axi.S_AXI_WSTRB;
      end
      if (bvalid_q && s_axi.S_AXI_BREADY) begin
        bvalid_d = 1'b0;
      end
    end
  end

  // Reads sample regs_q, so a same-cycle write to the same register is not yet visible
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_oor ? '0 : regs_q[s_axi.S_AXI_ARADDR[3:2]];
      rresp_d  = rd_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ready_q   <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      regs_q    <= '0;
      pulse_q   <= '0;
    end else begin
      ready_q   <= 1'b1;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
      pulse_q   <= pulse_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign reg_out             = regs_q;
  assign reg_wr_pulse        = pulse_q;

  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       wr_addr[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_axil_reg_responder.sv
// Directed bench for axil_reg_responder: register access, byte strobes, slot ordering,
// B backpressure, out-of-range accesses, read/write collision and mid-operation reset.
module tb_axil_reg_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axil_reg_responder_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) bus ();
  logic [127:0] reg_out;
  logic [3:0]   reg_wr_pulse;

  axil_reg_responder #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .ACLK         (clk),
    .ARESET       (rst),
    .s_axi        (bus),
    .reg_out      (reg_out),
    .reg_wr_pulse (reg_wr_pulse)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [3:0] pulse, output int lat);
    logic aw_go, w_go;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    lat = 0;
    while (!bus.S_AXI_BVALID && lat < 20) begin
      aw_go = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_go  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      step();
      lat++;
      if (aw_go) bus.S_AXI_AWVALID = 1'b0;
      if (w_go)  bus.S_AXI_WVALID  = 1'b0;
    end
    chk("write_timeout", 128'(bus.S_AXI_BVALID), 128'(1'b1));
    resp  = bus.S_AXI_BRESP;
    pulse = reg_wr_pulse;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    step();
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    logic ar_go;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    lat = 0;
    while (!bus.S_AXI_RVALID && lat < 20) begin
      ar_go = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      step();
      lat++;
      if (ar_go) bus.S_AXI_ARVALID = 1'b0;
    end
    chk("read_timeout", 128'(bus.S_AXI_RVALID), 128'(1'b1));
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    bus.S_AXI_ARVALID = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  resp;
    logic [3:0]  pulse;
    logic [31:0] rd;
    int          lat;

    rst = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_bvalid",  128'(bus.S_AXI_BVALID),  128'(1'b0));
    chk("rst_rvalid",  128'(bus.S_AXI_RVALID),  128'(1'b0));
    chk("rst_awready", 128'(bus.S_AXI_AWREADY), 128'(1'b0));
    chk("rst_arready", 128'(bus.S_AXI_ARREADY), 128'(1'b0));
    chk("rst_reg_out", reg_out, 128'h0);
    chk("rst_rdata",   128'(bus.S_AXI_RDATA),   128'h0);
    chk("rst_pulse",   128'(reg_wr_pulse),      128'h0);
    rst = 1'b0;
    chk("post_rst_wready", 128'(bus.S_AXI_WREADY), 128'(1'b0));
    step();
    chk("rdy_awready", 128'(bus.S_AXI_AWREADY), 128'(1'b1));
    chk("rdy_wready",  128'(bus.S_AXI_WREADY),  128'(1'b1));
    chk("rdy_arready", 128'(bus.S_AXI_ARREADY), 128'(1'b1));

    // Basic write / read of all four registers
    axi_write(5'h00, 32'h1, 4'hF, resp, pulse, lat);
    chk("wr0_resp",  128'(resp),  128'(2'b00));
    chk("wr0_pulse", 128'(pulse), 128'(4'b0001));
    chk("wr0_lat",   128'(lat),   128'(1));
    axi_write(5'h04, 32'h2, 4'hF, resp, pulse, lat);
    chk("wr1_pulse", 128'(pulse), 128'(4'b0010));
    axi_write(5'h08, 32'h3, 4'hF, resp, pulse, lat);
    chk("wr2_pulse", 128'(pulse), 128'(4'b0100));
    axi_write(5'h0C, 32'h4, 4'hF, resp, pulse, lat);
    chk("wr3_pulse", 128'(pulse), 128'(4'b1000));
    chk("wr3_resp",  128'(resp),  128'(2'b00));
    chk("wr_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);

    axi_read(5'h00, rd, resp, lat);
    chk("rd0_data", 128'(rd),   128'h1);
    chk("rd0_resp", 128'(resp), 128'(2'b00));
    chk("rd0_lat",  128'(lat),  128'(1));
    axi_read(5'h04, rd, resp, lat);
    chk("rd1_data", 128'(rd), 128'h2);
    axi_read(5'h08, rd, resp, lat);
    chk("rd2_data", 128'(rd), 128'h3);
    axi_read(5'h0E, rd, resp, lat);
    chk("rd3_data", 128'(rd),   128'h4);
    chk("rd3_resp", 128'(resp), 128'(2'b00));

    // Byte strobes
    axi_write(5'h04, 32'hFFFFFFFF, 4'hF, resp, pulse, lat);
    chk("strb_full_pulse", 128'(pulse), 128'(4'b0010));
    axi_write(5'h04, 32'h12345678, 4'b0101, resp, pulse, lat);
    chk("strb_part_pulse", 128'(pulse), 128'(4'b0010));
    chk("strb_reg_out", reg_out, 128'h00000004_00000003_FF34FF78_00000001);

    // Zero strobe: OKAY and pulse, data untouched
    axi_write(5'h0C, 32'hDEADBEEF, 4'b0000, resp, pulse, lat);
    chk("strb0_resp",  128'(resp),  128'(2'b00));
    chk("strb0_pulse", 128'(pulse), 128'(4'b1000));
    chk("strb0_reg3",  128'(reg_out[127:96]), 128'h4);

    // W three cycles ahead of AW
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_WDATA = 32'hA5A5A5A5; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    step();
    bus.S_AXI_WVALID = 1'b0;
    chk("wfirst_wready0", 128'(bus.S_AXI_WREADY), 128'(1'b0));
    step(); step();
    chk("wfirst_wready2", 128'(bus.S_AXI_WREADY), 128'(1'b0));
    chk("wfirst_bvalid",  128'(bus.S_AXI_BVALID), 128'(1'b0));
    chk("wfirst_reg2_old", 128'(reg_out[95:64]), 128'h3);
    bus.S_AXI_AWADDR = 5'h08; bus.S_AXI_AWVALID = 1'b1;
    step();
    bus.S_AXI_AWVALID = 1'b0;
    chk("wfirst_bvalid_aw", 128'(bus.S_AXI_BVALID), 128'(1'b1));
    chk("wfirst_reg2_new",  128'(reg_out[95:64]),   128'hA5A5A5A5);
    chk("wfirst_pulse",     128'(reg_wr_pulse),     128'(4'b0100));
    chk("wfirst_wready_b",  128'(bus.S_AXI_WREADY), 128'(1'b1));
    step();
    chk("wfirst_bdone", 128'(bus.S_AXI_BVALID), 128'(1'b0));

    // B backpressure with a second write queued in the slots
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_AWADDR = 5'h00; bus.S_AXI_WDATA = 32'h11111111; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    step();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    chk("bp_b1_valid", 128'(bus.S_AXI_BVALID), 128'(1'b1));
    chk("bp_reg0",     128'(reg_out[31:0]),    128'h11111111);
    bus.S_AXI_AWADDR = 5'h04; bus.S_AXI_WDATA = 32'h22222222;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    step();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    chk("bp_awready", 128'(bus.S_AXI_AWREADY), 128'(1'b0));
    chk("bp_wready",  128'(bus.S_AXI_WREADY),  128'(1'b0));
    chk("bp_bresp",   128'(bus.S_AXI_BRESP),   128'(2'b00));
    chk("bp_reg1_held", 128'(reg_out[63:32]), 128'hFF34FF78);
    step(); step(); step();
    chk("bp_bvalid_held", 128'(bus.S_AXI_BVALID),  128'(1'b1));
    chk("bp_awready_held", 128'(bus.S_AXI_AWREADY), 128'(1'b0));
    chk("bp_reg1_held2",  128'(reg_out[63:32]),    128'hFF34FF78);
    bus.S_AXI_BREADY = 1'b1;
    step();
    chk("bp_b2_valid", 128'(bus.S_AXI_BVALID), 128'(1'b1));
    chk("bp_reg1_new", 128'(reg_out[63:32]),   128'h22222222);
    chk("bp_b2_pulse", 128'(reg_wr_pulse),     128'(4'b0010));
    step();
    chk("bp_b2_done",  128'(bus.S_AXI_BVALID),  128'(1'b0));
    chk("bp_awready_back", 128'(bus.S_AXI_AWREADY), 128'(1'b1));

    // Out-of-range write and read
    axi_write(5'h10, 32'hDEADBEEF, 4'hF, resp, pulse, lat);
    chk("oor_bresp", 128'(resp),  128'(2'b10));
    chk("oor_pulse", 128'(pulse), 128'(4'b0000));
    chk("oor_reg_out", reg_out, 128'h00000004_A5A5A5A5_22222222_11111111);
    axi_read(5'h14, rd, resp, lat);
    chk("oor_rresp", 128'(resp), 128'(2'b10));
    chk("oor_rdata", 128'(rd),   128'h0);

    // Read and write to reg0 in the same cycle: read sees the old value
    bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = 5'h00; bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_AWADDR = 5'h00; bus.S_AXI_WDATA = 32'h00000055; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    step();
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    chk("rw_rvalid", 128'(bus.S_AXI_RVALID), 128'(1'b1));
    chk("rw_rdata",  128'(bus.S_AXI_RDATA),  128'h11111111);
    chk("rw_bvalid", 128'(bus.S_AXI_BVALID), 128'(1'b1));
    chk("rw_reg0",   128'(reg_out[31:0]),    128'h55);
    step();
    chk("rw_rdone", 128'(bus.S_AXI_RVALID), 128'(1'b0));

    // R held under RREADY=0
    bus.S_AXI_RREADY = 1'b0;
    bus.S_AXI_ARADDR = 5'h08; bus.S_AXI_ARVALID = 1'b1;
    step();
    bus.S_AXI_ARVALID = 1'b0;
    chk("rhold_arready", 128'(bus.S_AXI_ARREADY), 128'(1'b0));
    step(); step();
    chk("rhold_rvalid", 128'(bus.S_AXI_RVALID), 128'(1'b1));
    chk("rhold_rdata",  128'(bus.S_AXI_RDATA),  128'hA5A5A5A5);
    bus.S_AXI_RREADY = 1'b1;
    step();
    chk("rhold_done",    128'(bus.S_AXI_RVALID),  128'(1'b0));
    chk("rhold_arready1", 128'(bus.S_AXI_ARREADY), 128'(1'b1));

    // Reset while both responses pending and an AW parked in its slot
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    bus.S_AXI_AWADDR = 5'h0C; bus.S_AXI_WDATA = 32'h77; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 5'h00; bus.S_AXI_ARVALID = 1'b1;
    step();
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_AWADDR = 5'h04;
    chk("mr_bvalid_pre", 128'(bus.S_AXI_BVALID), 128'(1'b1));
    chk("mr_rvalid_pre", 128'(bus.S_AXI_RVALID), 128'(1'b1));
    step();
    bus.S_AXI_AWVALID = 1'b0;
    rst = 1'b1;
    step();
    chk("mr_bvalid",  128'(bus.S_AXI_BVALID),  128'(1'b0));
    chk("mr_rvalid",  128'(bus.S_AXI_RVALID),  128'(1'b0));
    chk("mr_reg_out", reg_out, 128'h0);
    chk("mr_rdata",   128'(bus.S_AXI_RDATA),   128'h0);
    chk("mr_bresp",   128'(bus.S_AXI_BRESP),   128'(2'b00));
    chk("mr_awready", 128'(bus.S_AXI_AWREADY), 128'(1'b0));
    rst = 1'b0;
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    step();
    chk("mr_wready_up", 128'(bus.S_AXI_WREADY), 128'(1'b1));
    bus.S_AXI_WDATA = 32'h99; bus.S_AXI_WVALID = 1'b1;
    step();
    bus.S_AXI_WVALID = 1'b0;
    step(); step();
    chk("mr_no_bvalid", 128'(bus.S_AXI_BVALID),  128'(1'b0));
    chk("mr_no_rvalid", 128'(bus.S_AXI_RVALID),  128'(1'b0));
    chk("mr_reg_out2",  reg_out, 128'h0);
    chk("mr_awready2",  128'(bus.S_AXI_AWREADY), 128'(1'b1));
    chk("mr_wready2",   128'(bus.S_AXI_WREADY),  128'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
